// File: rtl/alu_pkg.sv
// Shared constants for the vector ALU: major opcode, function codes, lane-width encodings.
package alu_pkg;

  localparam int unsigned DW = 64;

  localparam logic [5:0] ALU_OP = 6'b101010;

  localparam logic [5:0] F_VAND   = 6'b000001;
  localparam logic [5:0] F_VOR    = 6'b000010;
  localparam logic [5:0] F_VXOR   = 6'b000011;
  localparam logic [5:0] F_VNOT   = 6'b000100;
  localparam logic [5:0] F_VMOV   = 6'b000101;
  localparam logic [5:0] F_VADD   = 6'b000110;
  localparam logic [5:0] F_VSUB   = 6'b000111;
  localparam logic [5:0] F_VMULEU = 6'b001000;
  localparam logic [5:0] F_VMULOU = 6'b001001;
  localparam logic [5:0] F_VSLL   = 6'b001010;
  localparam logic [5:0] F_VSRL   = 6'b001011;
  localparam logic [5:0] F_VSRA   = 6'b001100;
  localparam logic [5:0] F_VRTTH  = 6'b001101;
  localparam logic [5:0] F_VDIV   = 6'b001110;
  localparam logic [5:0] F_VMOD   = 6'b001111;
  localparam logic [5:0] F_VSQEU  = 6'b010000;
  localparam logic [5:0] F_VSQOU  = 6'b010001;
  localparam logic [5:0] F_VSQRT  = 6'b010010;

  localparam logic [1:0] W8  = 2'b00;
  localparam logic [1:0] W16 = 2'b01;
  localparam logic [1:0] W32 = 2'b10;
  localparam logic [1:0] W64 = 2'b11;

endpackage

// File: rtl/alu_lane_sqrt.sv
// Combinational floor(sqrt(val)) for one W-bit lane, one result bit per step from the MSB.
module alu_lane_sqrt #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]   val,
  output logic [W/2-1:0] root
);

  localparam int unsigned RW = W / 2;

  logic [RW-1:0] acc;
  logic [RW-1:0] trial;

  always_comb begin
    acc   = '0;
    trial = '0;
    for (int i = RW - 1; i >= 0; i--) begin
      trial    = acc;
      trial[i] = 1'b1;
      if (W'(trial) * W'(trial) <= val) acc = trial;
    end
  end

  assign root = acc;

endmodule

// File: rtl/alu.sv
// Vector integer ALU, 64-bit datapath split into 8/16/32/64-bit lanes, one registered result per cycle.
// Optional divider (VDIV/VMOD) built only when ALU_DIV_EN is defined.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:63] rA_64bit_val,
  input  logic [0:63] rB_64bit_val,
  input  logic [5:0]  R_ins,
  input  logic [5:0]  Op_code,
  input  logic [1:0]  WW,
  output logic [0:63] ALU_out
);

  // Internal view is [63:0]; bit 0 of the ports maps onto bit 63 here, so lane 0 sits at the top.
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] nxt;
  logic [DW-1:0] w_lane [4];
  logic [DW-1:0] w_mul  [4];

  assign a = rA_64bit_val;
  assign b = rB_64bit_val;

  for (genvar g = 0; g < 4; g++) begin : g_w
    localparam int unsigned LW = 8 << g;
    localparam int unsigned NL = DW / LW;
    localparam int unsigned SW = $clog2(LW);
    localparam int unsigned PW = 2 * LW;

    for (genvar k = 0; k < NL; k++) begin : g_lane
      logic [LW-1:0]   la;
      logic [LW-1:0]   lb;
      logic [LW-1:0]   lr;
      logic [LW/2-1:0] root;

      assign la = a[k*LW +: LW];
      assign lb = b[k*LW +: LW];

      alu_lane_sqrt #(.W(LW)) u_sqrt (
        .val  (la),
        .root (root)
      );

      always_comb begin
        lr = '0;
        case (R_ins)
          F_VADD:  lr = la + lb;
          F_VSUB:  lr = la - lb;
          F_VSLL:  lr = la << lb[SW-1:0];
          F_VSRL:  lr = la >> lb[SW-1:0];
          F_VSRA:  lr = $signed(la) >>> lb[SW-1:0];
          F_VRTTH: lr = {la[LW/2-1:0], la[LW-1:LW/2]};
          F_VSQRT: lr = {{(LW/2){1'b0}}, root};
`ifdef ALU_DIV_EN
          F_VDIV:  lr = (lb == '0) ? '0 : la / lb;
          F_VMOD:  lr = (lb == '0) ? '0 : la % lb;
`endif
          default: lr = '0;
        endcase
      end

      assign w_lane[g][k*LW +: LW] = lr;
    end

    // Widening ops: each 2w slot takes the product of its upper (even) or lower (odd) lane.
    if (g < 3) begin : g_mul
      for (genvar p = 0; p < NL / 2; p++) begin : g_pair
        logic [LW-1:0] ea, eb, oa, ob;
        logic [PW-1:0] mr;

        assign ea = a[p*PW + LW +: LW];
        assign eb = b[p*PW + LW +: LW];
        assign oa = a[p*PW +: LW];
        assign ob = b[p*PW +: LW];

        always_comb begin
          mr = '0;
          case (R_ins)
            F_VMULEU: mr = PW'(ea) * PW'(eb);
            F_VMULOU: mr = PW'(oa) * PW'(ob);
            F_VSQEU:  mr = PW'(ea) * PW'(ea);
            F_VSQOU:  mr = PW'(oa) * PW'(oa);
            default:  mr = '0;
          endcase
        end

        assign w_mul[g][p*PW +: PW] = mr;
      end
    end else begin : g_nomul
      assign w_mul[g] = '0;
    end
  end

  // Next-result select: full-width logic ops bypass lane width.
  always_comb begin
    nxt = '0;
    if (Op_code == ALU_OP) begin
      case (R_ins)
        F_VAND: nxt = a & b;
        F_VOR:  nxt = a | b;
        F_VXOR: nxt = a ^ b;
        F_VNOT: nxt = ~a;
        F_VMOV: nxt = a;
        F_VMULEU, F_VMULOU, F_VSQEU, F_VSQOU: begin
          case (WW)
            W8:      nxt = w_mul[0];
            W16:     nxt = w_mul[1];
            W32:     nxt = w_mul[2];
            W64:     nxt = w_mul[3];
            default: nxt = '0;
          endcase
        end
        default: begin
          case (WW)
            W8:      nxt = w_lane[0];
            W16:     nxt = w_lane[1];
            W32:     nxt = w_lane[2];
            W64:     nxt = w_lane[3];
            default: nxt = '0;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ALU_out <= '0;
    else        ALU_out <= nxt;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus randomized ops against a lane-level model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:63] ra = '0;
  logic [0:63] rb = '0;
  logic [5:0]  r_ins = '0;
  logic [5:0]  op_code = '0;
  logic [1:0]  ww = '0;
  logic [0:63] alu_out;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [5:0] OPC = 6'b101010;

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rA_64bit_val (ra),
    .rB_64bit_val (rb),
    .R_ins        (r_ins),
    .Op_code      (op_code),
    .WW           (ww),
    .ALU_out      (alu_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %016h expected %016h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] isqrt(input logic [127:0] x);
    logic [127:0] lo, hi, mid;
    lo = 0;
    hi = 128'h1_0000_0000;
    while (hi - lo > 1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  // Reference: lanes counted from the MSB, computed with wide unsigned arithmetic.
  function automatic logic [63:0] model(input logic [5:0] opc, input logic [5:0] f,
                                        input logic [1:0] wsel, input logic [63:0] a,
                                        input logic [63:0] b);
    int unsigned w, n, sh, amt, src;
    logic [127:0] m, la, lb, lr;
    logic [63:0] r;
    w = 8 << wsel;
    n = 64 / w;
    m = (128'd1 << w) - 1;
    r = '0;
    if (opc != OPC) return '0;
    case (f)
      6'b000001: return a & b;
      6'b000010: return a | b;
      6'b000011: return a ^ b;
      6'b000100: return ~a;
      6'b000101: return a;
      6'b001000, 6'b001001, 6'b010000, 6'b010001: begin
        if (w == 64) return '0;
        for (int p = 0; p < int'(n / 2); p++) begin
          src = (f[0] == 1'b0) ? 2 * p : 2 * p + 1;
          sh  = 64 - (src + 1) * w;
          la  = (128'(a) >> sh) & m;
          lb  = (128'(b) >> sh) & m;
          lr  = (f[4] == 1'b1) ? la * la : la * lb;
          r   = r | 64'(lr << (64 - (p + 1) * 2 * w));
        end
        return r;
      end
      default: ;
    endcase
    for (int i = 0; i < int'(n); i++) begin
      sh  = 64 - (i + 1) * w;
      la  = (128'(a) >> sh) & m;
      lb  = (128'(b) >> sh) & m;
      amt = 32'(lb % 128'(w));
      case (f)
        6'b000110: lr = (la + lb) & m;
        6'b000111: lr = (la - lb) & m;
        6'b001010: lr = (la << amt) & m;
        6'b001011: lr = la >> amt;
        6'b001100: begin
          lr = la >> amt;
          if (la[w-1]) lr = lr | (m & ~(m >> amt));
        end
        6'b001101: lr = ((la << (w / 2)) | (la >> (w / 2))) & m;
        6'b010010: lr = isqrt(la);
`ifdef ALU_DIV_EN
        6'b001110: lr = (lb == 0) ? 0 : la / lb;
        6'b001111: lr = (lb == 0) ? 0 : la % lb;
`endif
        default:   lr = 0;
      endcase
      r = r | 64'(lr << sh);
    end
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [5:0] f, input logic [1:0] wsel,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    @(negedge clk);
    op_code = OPC;
    r_ins   = f;
    ww      = wsel;
    ra      = a;
    rb      = b;
    @(posedge clk);
    #1;
    check_eq(tag, alu_out, exp);
  endtask

  initial begin
    logic [63:0] a, b;
    logic [5:0]  f, opc;
    logic [1:0]  wsel;

    #12;
    check_eq("reset_state", alu_out, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("vand", 6'b000001, 2'b00, 64'd15, 64'd14, 64'd14);
    run_op("vor",  6'b000010, 2'b01, 64'd15, 64'd14, 64'd15);
    run_op("vxor", 6'b000011, 2'b11, 64'd15, 64'd14, 64'd1);
    run_op("vnot", 6'b000100, 2'b10, 64'd0, 64'd0, 64'hFFFFFFFF_FFFFFFFF);
    run_op("vadd_w8", 6'b000110, 2'b00, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111,
           64'hFFFFFFFF_10101010);
    run_op("vadd_w64", 6'b000110, 2'b11, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111,
           64'h00000000_11111110);
    run_op("vmuleu_w16", 6'b001000, 2'b01, 64'hFF000000_FFFFFFFF, 64'h00020000_000F0001,
           64'h0001FE00_000EFFF1);
    run_op("vmulou_w32", 6'b001001, 2'b10, 64'd32, 64'd32, 64'h400);
    run_op("vmul_w64_zero", 6'b001000, 2'b11, 64'h12345678_9ABCDEF0, 64'h5, 64'h0);
    run_op("vsqrt_w8", 6'b010010, 2'b00, 64'hFF01FFFF_10040001, 64'h0, 64'h0F010F0F_04020001);
    run_op("vsra_w16", 6'b001100, 2'b01, 64'hF0E1F2A2_01010101, 64'h00030003_00030003,
           64'hFE1CFE54_00200020);
    run_op("vrtth_w64", 6'b001101, 2'b11, 64'hFFFFFFFF_00000000, 64'h0, 64'h00000000_FFFFFFFF);
`ifdef ALU_DIV_EN
    run_op("vdiv_zero_lane", 6'b001110, 2'b00, 64'h64646464_64646464, 64'h0A000A05_01020304,
           64'h0A000A14_64322119);
`else
    run_op("vdiv_zero_lane", 6'b001110, 2'b00, 64'h64646464_64646464, 64'h0A000A05_01020304,
           64'h0);
`endif
    run_op("bad_rins", 6'b111111, 2'b00, 64'hFFFF, 64'hFFFF, 64'h0);

    @(negedge clk);
    op_code = 6'b000000;
    r_ins   = 6'b000101;
    ra      = 64'hDEADBEEF_DEADBEEF;
    @(posedge clk);
    #1;
    check_eq("bad_opcode", alu_out, 64'h0);

    // Reset mid-stream: clears immediately and holds through an edge.
    @(negedge clk);
    op_code = OPC;
    r_ins   = 6'b000101;
    ra      = 64'hA5A5A5A5_5A5A5A5A;
    @(posedge clk);
    #1;
    check_eq("pre_reset", alu_out, 64'hA5A5A5A5_5A5A5A5A);
    ra = 64'h11112222_33334444;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("reset_async", alu_out, 64'h0);
    @(posedge clk);
    #1;
    check_eq("reset_hold", alu_out, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("reset_release", alu_out, 64'h11112222_33334444);

    for (int it = 0; it < 400; it++) begin
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      f    = ($urandom_range(0, 19) == 19) ? 6'($urandom) : 6'($urandom_range(1, 18));
      wsel = 2'($urandom);
      opc  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OPC;
      if (it % 7 == 0) b = b & 64'hFF00FF00_00FF00FF;
      @(negedge clk);
      op_code = opc;
      r_ins   = f;
      ww      = wsel;
      ra      = a;
      rb      = b;
      @(posedge clk);
      #1;
      check_eq($sformatf("rand_f%02h_w%0d", f, wsel), alu_out, model(opc, f, wsel, a, b));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
